// File: rtl/result_uart_tx_pkg.sv
// Shared constants for the result UART transmitter: 8N1 frame bits and FSM encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package result_uart_tx_pkg;

  // 8N1 frame: one low start bit, eight data bits LSB first, one high stop bit.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Latency: a pushed word is visible at dout_o and counted in level_o one cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle; pops while empty are ignored.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   push_i, din_i    write request and data
//   pop_i, dout_o    read request and head-of-queue data (combinational read of the head)
//   full_o, empty_o  occupancy flags derived from the registered level
//   level_o          registered occupancy, 0..DEPTH
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   level_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_level == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign dout_o  = r_mem[r_rd_ptr];

  // A pop frees the head slot on the same edge, so a push into a full FIFO is fine then.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Storage needs no reset: nothing is read until level says it was written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Queues classifier result words and sends each one off-chip as an 8N1 UART frame.
// Latency: a result accepted into an empty FIFO with the line idle drives the start bit one cycle later.
// Backpressure: none upstream; results arriving while the FIFO is full are dropped and flagged sticky on overflow_o.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset (aborts any frame and flushes the queue)
//   result_valid_i   one-cycle strobe qualifying result_i
//   result_i         result word, zero-extended to a byte on the line
//   tx_o             serial line, idles high
//   busy_o           a frame is on the line or results are queued
//   level_o          registered FIFO occupancy
//   overflow_o       sticky: at least one result was lost since reset
import result_uart_tx_pkg::*;

module result_uart_tx #(
  parameter int RES_W        = 7,
  parameter int FIFO_DEPTH   = 4,
  parameter int PTR_W        = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             result_valid_i,
  input  logic [RES_W-1:0] result_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic [PTR_W:0]   level_o,
  output logic             overflow_o
);

  uart_state_t      r_state;
  uart_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_ovf;

  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic             w_pop;
  logic             w_busy;
  logic             w_bit_end;
  logic             w_last_bit;

  result_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (result_valid_i),
    .din_i   (8'(result_i)),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign w_bit_end  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_idx == 3'(DATA_BITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. STOP chains straight into START when work is queued,
  // so consecutive frames have no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_bit_end && w_last_bit) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_end) w_state_nxt = w_empty ? S_IDLE : S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: pop the head whenever a new frame begins.
  always_comb begin
    w_pop  = 1'b0;
    w_busy = (r_state != S_IDLE) || !w_empty;
    if (!w_empty) begin
      if (r_state == S_IDLE)                w_pop = 1'b1;
      if (r_state == S_STOP && w_bit_end)   w_pop = 1'b1;
    end
  end

  // Datapath: bit-period counter, shift register, line driver, overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx    <= STOP_BIT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (result_valid_i && w_full && !w_pop) r_ovf <= 1'b1;

      if (w_pop) begin
        r_shift <= w_head;
        r_tx    <= START_BIT;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          S_START: begin
            if (w_bit_end) begin
              r_cnt <= '0;
              r_tx  <= r_shift[0];
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_cnt <= '0;
              if (w_last_bit) begin
                r_tx <= STOP_BIT;
              end else begin
                // r_shift[1] is bit 0 of the shifted value, i.e. the next data bit.
                r_shift <= r_shift >> 1;
                r_idx   <= r_idx + 1'b1;
                r_tx    <= r_shift[1];
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (w_bit_end) r_cnt <= '0;
            else           r_cnt <= r_cnt + 1'b1;
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign tx_o       = r_tx;
  assign busy_o     = w_busy;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_result_uart_tx.sv
module tb_result_uart_tx;

  logic       clk;
  logic       rstn;
  logic       result_valid_i;
  logic [6:0] result_i;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] level_o;
  logic       overflow_o;

  int errors;
  int checks;

  result_uart_tx #(
    .RES_W        (7),
    .FIFO_DEPTH   (4),
    .PTR_W        (2),
    .CLKS_PER_BIT (4),
    .CNT_W        (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .result_valid_i (result_valid_i),
    .result_i       (result_i),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    result_valid_i = 1'b0;
    result_i = '0;
    step();
    rstn = 1'b1;
  endtask

  // Expected line level k cycles into a frame of byte b (k=1 is the start edge),
  // 4 clocks per bit: start 1..4, data bits 5..36 LSB first, stop 37..40.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k <= 4)  return 1'b0;
    if (k <= 36) return b[(k - 5) / 4];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    result_valid_i = 1'b0;
    result_i = '0;
    step();
    checks++; if (tx_o !== 1'b1)        begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (level_o !== 3'd0)     begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (overflow_o !== 1'b0)  begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0 || overflow_o !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc=%0d got tx=%b busy=%b lvl=%0d ovf=%b exp 1 0 0 0", i, tx_o, busy_o, level_o, overflow_o);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k <= 41; k++) begin
      result_valid_i = (k == 0);
      result_i = 7'h35;
      step();
      if (k == 0) begin
        checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level_o); end
        checks++; if (busy_o !== 1'b1)  begin errors++; $display("FAIL single_busy_rise got=%b exp=1", busy_o); end
      end
      if (k >= 1 && k <= 40) begin
        checks++;
        if (tx_o !== exp_tx(8'h35, k)) begin
          errors++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, tx_o, exp_tx(8'h35, k));
        end
      end
      if (k == 40) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_hold got=%b exp=1", busy_o); end
      end
      if (k == 41) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", busy_o); end
        checks++; if (tx_o !== 1'b1)   begin errors++; $display("FAIL single_tx_idle got=%b exp=1", tx_o); end
      end
    end
    result_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] vals [3];
    logic [7:0] b;
    int         peak;
    vals[0] = 7'h03; vals[1] = 7'h09; vals[2] = 7'h7F;
    peak = 0;
    do_reset();
    for (int k = 0; k <= 121; k++) begin
      result_valid_i = (k < 3);
      result_i = (k < 3) ? vals[k] : 7'h00;
      step();
      if (int'(level_o) > peak) peak = int'(level_o);
      if (k >= 1 && k <= 120) begin
        b = {1'b0, vals[(k - 1) / 40]};
        checks++;
        if (tx_o !== exp_tx(b, ((k - 1) % 40) + 1)) begin
          errors++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, tx_o, exp_tx(b, ((k - 1) % 40) + 1));
        end
      end
    end
    result_valid_i = 1'b0;
    checks++; if (peak != 2)            begin errors++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
    checks++; if (overflow_o !== 1'b0)  begin errors++; $display("FAIL b2b_ovf got=%b exp=0", overflow_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy_o); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    for (int k = 0; k <= 201; k++) begin
      result_valid_i = (k == 0) || (k >= 2 && k <= 7);
      result_i = (k == 0) ? 7'h11 : 7'(32'h20 + k - 1);
      step();
      if (k == 5) begin
        checks++; if (level_o !== 3'd4)    begin errors++; $display("FAIL ovf_full_level got=%0d exp=4", level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", overflow_o); end
      end
      if (k == 6) begin
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
        checks++; if (level_o !== 3'd4)    begin errors++; $display("FAIL ovf_level got=%0d exp=4", level_o); end
      end
      if (k == 7) begin
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_held got=%b exp=1", overflow_o); end
      end
      if (k >= 1 && k <= 200) begin
        b = (k <= 40) ? 8'h11 : 8'(32'h20 + (k - 1) / 40);
        checks++;
        if (tx_o !== exp_tx(b, ((k - 1) % 40) + 1)) begin
          errors++; $display("FAIL ovf_tx k=%0d got=%b exp=%b", k, tx_o, exp_tx(b, ((k - 1) % 40) + 1));
        end
      end
    end
    result_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL ovf_busy_end got=%b exp=0", busy_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] b;
    do_reset();
    for (int k = 0; k <= 241; k++) begin
      result_valid_i = (k == 0) || (k >= 2 && k <= 5) || (k == 41);
      result_i = (k == 0) ? 7'h05 : (k == 41) ? 7'h45 : 7'(32'h40 + k - 1);
      step();
      if (k == 40) begin
        checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL pp_level_pre got=%0d exp=4", level_o); end
      end
      if (k == 41) begin
        checks++; if (level_o !== 3'd4)    begin errors++; $display("FAIL pp_level got=%0d exp=4", level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL pp_ovf got=%b exp=0", overflow_o); end
      end
      if (k >= 1 && k <= 240) begin
        b = (k <= 40) ? 8'h05 : 8'(32'h40 + (k - 1) / 40);
        checks++;
        if (tx_o !== exp_tx(b, ((k - 1) % 40) + 1)) begin
          errors++; $display("FAIL pp_tx k=%0d got=%b exp=%b", k, tx_o, exp_tx(b, ((k - 1) % 40) + 1));
        end
      end
    end
    result_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL pp_busy_end got=%b exp=0", busy_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL pp_ovf_end got=%b exp=0", overflow_o); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int k = 0; k <= 15; k++) begin
      result_valid_i = (k < 3);
      result_i = 7'(32'h0A + k);
      step();
    end
    result_valid_i = 1'b0;
    // 15 cycles into the 0x0A frame: data bit 2 of 0x0A is 0.
    checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL mid_level got=%0d exp=2", level_o); end
    checks++; if (tx_o !== 1'b0)    begin errors++; $display("FAIL mid_tx got=%b exp=0", tx_o); end
    rstn = 1'b0;
    step();
    checks++; if (tx_o !== 1'b1)       begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", tx_o); end
    checks++; if (level_o !== 3'd0)    begin errors++; $display("FAIL mid_rst_level got=%0d exp=0", level_o); end
    checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%b exp=0", overflow_o); end
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || level_o !== 3'd0) begin
        errors++;
        $display("FAIL post_rst cyc=%0d got tx=%b busy=%b lvl=%0d exp 1 0 0", i, tx_o, busy_o, level_o);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    result_valid_i = 1'b0;
    result_i = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream consumer of the classifier output stage.
- Captures each result word on its one-cycle valid pulse into a small synchronous FIFO.
- Serialises each word off-chip as one 8N1 UART frame, so results can be read on a pin with no host bus.
- Decouples bursts of results from the slow serial line and flags lost results.

Parameters:
- RES_W, 7, width of result word; must be <= 8.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- PTR_W, 2, log2(FIFO_DEPTH).
- CLKS_PER_BIT, 16, clk cycles per UART bit; >= 2.
- CNT_W, 5, width of bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- result_valid_i  input  1  one-cycle pulse; result_i valid this cycle.
- result_i  input  RES_W  result word from the classifier output stage.
- tx_o  output  1  UART serial line; idles high.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- level_o  output  PTR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow_o  output  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Clocking and reset
  - One clock (clk). Reset is synchronous, active-low (rstn).
  - With rstn=0 at an edge: tx_o=1, busy_o=0, level_o=0, overflow_o=0, FSM=IDLE, FIFO pointers=0, counters=0.
  - Reset mid-frame aborts the frame: tx_o returns high at that edge and queued results are discarded.
- FIFO
  - Push when result_valid_i=1 and (not full, or a pop occurs in the same cycle).
  - Stored byte = zero-extended result_i to 8 bits.
  - Push when full with no simultaneous pop: word dropped, overflow_o<=1, held until reset.
  - Simultaneous push and pop: occupancy unchanged; the FIFO never overflows in this case.
  - Pointers wrap modulo FIFO_DEPTH. level_o is registered.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when FIFO non-empty (registered level != 0). Same edge: pop head into 8-bit shift register, tx_o<=0, bit counter<=0, bit index<=0.
  - START: hold tx_o=0 for CLKS_PER_BIT cycles. On the last cycle go to DATA and drive tx_o<=shift[0].
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. At each bit end shift right and increment the bit index. After bit 7, go to STOP with tx_o<=1.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START with tx_o<=0 (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame timing
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Latency: result_valid_i sampled at edge t, FIFO empty, FSM in IDLE -> tx_o falls at edge t+1.
- Status
  - A result arriving while the FSM is idle is still written through the FIFO; there is no bypass path.
  - busy_o = (FSM != IDLE) or (level != 0), registered-equivalent. It drops the cycle after the last STOP bit ends with the FIFO empty.
- Illegal result_i bits beyond RES_W do not exist; the upper byte bits are always 0.

Decomposition:
- Shared include/package holds:
  - UART frame constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
  - FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3.
- One natural sub-module: result_fifo.
  - Parameterised synchronous FIFO with push, pop, full, empty, level.
  - Reusable elsewhere in the design.
- Top level contains the FSM, bit counter, shift register and overflow flag.

Test Plan:
- Use CLKS_PER_BIT=4 for all scenarios below.
1. Reset then idle 50 cycles -> tx_o=1, busy_o=0, level_o=0, overflow_o=0 throughout.
2. Single pulse result_i=7'h35 at edge t -> tx_o low from edge t+1 for 4 cycles. Then bits 1,0,1,0,1,1,0,0, each 4 cycles. Then stop high 4 cycles. busy_o falls at t+41.
3. Pulses of 3, 9, 0x7F on consecutive cycles -> three back-to-back 40-cycle frames with no idle gap between stop and start. level_o peaks at 2. overflow_o=0.
4. Six pulses, one per cycle, during an active frame with FIFO_DEPTH=4 -> first four queued. Fifth and sixth dropped; overflow_o=1 from the fifth push edge, held. Four frames follow.
5. Push while full in the exact cycle STOP ends with a pop -> word accepted, level_o stays 4, overflow_o stays 0.
6. Assert rstn=0 for one cycle mid-DATA with 2 entries queued -> tx_o=1 at that edge, level_o=0. No further frames; outputs match reset values.
